adaptation_update_scheduler: RTL
================================

Name: adaptation_update_scheduler

Overview:
- Sequences the white-point adaptation loop: ALS read request, CCT capture, matrix recompute, matrix commit.
- Issues periodic or forced ALS reads and filters small CCT changes with hysteresis.
- Forwards accepted CCT values to the XYZ/Bradford chain.
- Commits a new compensation matrix to the image path only on a frame boundary while the image processor is idle, so a frame never mixes two matrices.

Parameters:
- PERIOD_CYCLES, 1000000, cycles between automatic ALS reads (min 2)
- HYST_K, 100, minimum |CCT delta| in Kelvin that triggers an update
- TIMEOUT_CYCLES, 65535, max cycles waiting for cct_valid or matrix_valid
- REF_CCT, 6500, applied CCT after reset (Kelvin)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  automatic periodic reads enabled
- force_read  in  1  single-cycle pulse: request an immediate read
- als_busy  in  1  ALS interface busy
- als_read_req  out  1  single-cycle read request to ALS interface
- cct_in  in  16  CCT from ALS (K)
- cct_valid  in  1  cct_in valid, single cycle
- cct_out  out  16  accepted CCT to converter
- cct_update  out  1  single-cycle strobe, cct_out is new
- matrix_valid  in  1  Bradford matrix ready, single cycle
- frame_start  in  1  single-cycle first-pixel-of-frame marker
- proc_busy  in  1  image processor busy
- matrix_commit  out  1  single-cycle strobe: image path loads the new matrix
- applied_cct  out  16  CCT of the currently committed matrix
- update_count  out  8  number of successful commits, wraps
- err_timeout  out  1  sticky timeout flag
- state_out  out  3  current FSM state encoding

Behaviour:
- Reset values (async, rst_n=0):
  - state IDLE; all strobes 0; err_timeout 0; update_count 0.
  - cct_out = applied_cct = REF_CCT; first_sample=1; timer=PERIOD_CYCLES-1; pending=0.
- Timer:
  - While enable=1, decrements each cycle. At 0 it generates a tick and reloads to PERIOD_CYCLES-1.
  - While enable=0, held at reload value. An in-flight sequence still completes.
- Read request sources: tick or force_read.
  - In IDLE, either source moves the FSM to READ_REQ next cycle.
  - Otherwise pending is set (one deep; further requests are dropped). Pending is consumed on the next IDLE cycle.
- State encodings: IDLE=0, READ_REQ=1, WAIT_CCT=2, COMPUTE=3, WAIT_FRAME=4, COMMIT=5.
- READ_REQ: stays while als_busy=1. When als_busy=0, drives als_read_req=1 for exactly that cycle, clears the timeout counter, and moves to WAIT_CCT.
- WAIT_CCT, on cct_valid:
  - delta = |cct_in - applied_cct|, computed 17-bit unsigned with no wrap.
  - If delta >= HYST_K or first_sample=1: register cct_out<=cct_in, pulse cct_update on the next cycle, clear first_sample, clear the timeout counter, go to COMPUTE.
  - Else: go to IDLE with no outputs changed.
- COMPUTE: on matrix_valid, go to WAIT_FRAME. A matrix_valid seen in any other state is ignored.
- Timeout in WAIT_CCT or COMPUTE:
  - The counter increments each cycle. When it reaches TIMEOUT_CYCLES, set err_timeout and go to IDLE.
  - applied_cct is unchanged. cct_out keeps its value (already sent if in COMPUTE).
- WAIT_FRAME: no timeout. Moves to COMMIT in the cycle after frame_start=1 with proc_busy=0. If proc_busy=1 at frame_start, it waits for a later frame_start.
- COMMIT, one cycle:
  - matrix_commit=1, applied_cct<=cct_out, update_count+1 (255 wraps to 0), err_timeout cleared.
  - Next state IDLE.
- Simultaneous events:
  - Tick and force_read in the same cycle count as one request.
  - cct_valid in the same cycle as the timeout limit: cct_valid wins.
- Latencies:
  - IDLE request to als_read_req: 1 cycle, with als_busy=0.
  - cct_valid to cct_update: 1 cycle.
  - Qualifying frame_start to matrix_commit: 1 cycle.
- Reset mid-operation: immediately returns to reset values. Any partially computed matrix is never committed.

Test Plan:
- Periodic read: PERIOD_CYCLES=100, enable=1, als_busy=0 -> first als_read_req at cycle 100 after reset release, then every 100 cycles; enable=0 -> no further requests.
- First sample: cct 6520 (delta 20, first_sample=1) -> cct_update, cct_out=6520; after matrix_valid and frame_start, matrix_commit and applied_cct=6520, update_count=1.
- Hysteresis reject then accept: applied 6520, cct 6580 -> no cct_update, FSM to IDLE. Next read with cct 4000 -> cct_update, cct_out=4000, commit, applied_cct=4000.
- Frame gating: matrix_valid given; frame_start with proc_busy=1 -> no commit; next frame_start with proc_busy=0 -> matrix_commit 1 cycle later.
- Timeout: TIMEOUT_CYCLES=50, no cct_valid -> err_timeout=1 at 50 cycles, IDLE, applied_cct unchanged. Next successful commit clears err_timeout.
- Contention/reset: force_read while in COMPUTE -> pending read issued right after COMMIT. Assert rst_n in WAIT_FRAME -> no matrix_commit, applied_cct=6500.

Source files
------------

// File: rtl/adaptation_update_scheduler.sv
// White-point adaptation sequencer: ALS read, CCT hysteresis filter, matrix
// recompute handshake and frame-aligned matrix commit.
module adaptation_update_scheduler #(
   parameter int unsigned PERIOD_CYCLES  = 1000000,
   parameter int unsigned HYST_K         = 100,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned REF_CCT        = 6500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        force_read,
   input  logic        als_busy,
   output logic        als_read_req,
   input  logic [15:0] cct_in,
   input  logic        cct_valid,
   output logic [15:0] cct_out,
   output logic        cct_update,
   input  logic        matrix_valid,
   input  logic        frame_start,
   input  logic        proc_busy,
   output logic        matrix_commit,
   output logic [15:0] applied_cct,
   output logic [7:0]  update_count,
   output logic        err_timeout,
   output logic [2:0]  state_out
);

   localparam int unsigned TMR_W = $clog2(PERIOD_CYCLES);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(PERIOD_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]      HYST       = 17'(HYST_K);
   localparam logic [15:0]      REF        = 16'(REF_CCT);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      READ_REQ   = 3'd1,
      WAIT_CCT   = 3'd2,
      COMPUTE    = 3'd3,
      WAIT_FRAME = 3'd4,
      COMMIT     = 3'd5
   } state_t;

   state_t            state, state_next;
   logic [TMR_W-1:0]  timer;
   logic [TO_W-1:0]   to_cnt;
   logic              pending;
   logic              first_sample;
   logic              tick_c, req_c;
   logic [16:0]       delta_c;
   logic              accept_c, timeout_hit_c, clr_to_c, take_req_c;

   assign tick_c        = enable && (timer == '0);
   assign req_c         = tick_c || force_read;
   assign als_read_req  = (state == READ_REQ) && !als_busy;
   assign matrix_commit = (state == COMMIT);
   assign state_out     = 3'(state);

   // Absolute CCT difference, one bit wider so it never wraps
   always_comb begin
      delta_c = '0;
      if (cct_in >= applied_cct) delta_c = 17'(cct_in) - 17'(applied_cct);
      else                       delta_c = 17'(applied_cct) - 17'(cct_in);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next    = state;
      accept_c      = 1'b0;
      timeout_hit_c = 1'b0;
      clr_to_c      = 1'b0;
      take_req_c    = 1'b0;
      case (state)
         IDLE: begin
            if (req_c || pending) begin
               take_req_c = 1'b1;
               state_next = READ_REQ;
            end
         end
         READ_REQ: begin
            if (!als_busy) begin
               clr_to_c   = 1'b1;
               state_next = WAIT_CCT;
            end
         end
         WAIT_CCT: begin
            // A sample arriving on the limit cycle still counts
            if (cct_valid) begin
               if (delta_c >= HYST || first_sample) begin
                  accept_c   = 1'b1;
                  clr_to_c   = 1'b1;
                  state_next = COMPUTE;
               end else begin
                  state_next = IDLE;
               end
            end else if (to_cnt == TO_LAST) begin
               timeout_hit_c = 1'b1;
               state_next    = IDLE;
            end
         end
         COMPUTE: begin
            if (matrix_valid) begin
               state_next = WAIT_FRAME;
            end else if (to_cnt == TO_LAST) begin
               timeout_hit_c = 1'b1;
               state_next    = IDLE;
            end
         end
         WAIT_FRAME: begin
            if (frame_start && !proc_busy) state_next = COMMIT;
         end
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Period timer, held at reload while automatic reads are disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       timer <= TMR_RELOAD;
      else if (!enable || timer == '0)  timer <= TMR_RELOAD;
      else                              timer <= timer - TMR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending      <= 1'b0;
         to_cnt       <= '0;
         first_sample <= 1'b1;
         cct_out      <= REF;
         cct_update   <= 1'b0;
         applied_cct  <= REF;
         update_count <= '0;
         err_timeout  <= 1'b0;
      end else begin
         if (take_req_c)                     pending <= 1'b0;
         else if (req_c && state != IDLE)    pending <= 1'b1;

         if (clr_to_c)                                    to_cnt <= '0;
         else if (state == WAIT_CCT || state == COMPUTE)  to_cnt <= to_cnt + TO_W'(1);

         cct_update <= accept_c;
         if (accept_c) begin
            cct_out      <= cct_in;
            first_sample <= 1'b0;
         end

         if (state == COMMIT) begin
            applied_cct  <= cct_out;
            update_count <= update_count + 8'd1;
            err_timeout  <= 1'b0;
         end else if (timeout_hit_c) begin
            err_timeout  <= 1'b1;
         end
      end
   end

endmodule
